highest_bit_scanner: RTL

Sequential most-significant-set-bit finder: accepts a WIDTH-bit word over a valid/ready handshake and scans it serially from the MSB down, one bit per clock. It returns the index of the highest set bit plus a found flag. It sits directly upstream of the 3-to-8 one-hot decoder:
- `pos` drives the decoder's `in`.
- `out_valid & found` drives the decoder's `en`.

Together they produce a one-hot "highest position" mask.

---
 rtl/highest_bit_scanner.sv | 78 +++++++
 1 files changed

// File: rtl/highest_bit_scanner.sv
// highest_bit_scanner: serial MSB-first scan returning the index of the highest set bit
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in accept a WIDTH-bit word;
//        out_valid/out_ready hand back pos (IDX_W-bit index, 0 when none) and found.
module highest_bit_scanner #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] pos,
    output logic             found
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [WIDTH-1:0] word;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            pos       <= '0;
            found     <= 1'b0;
            cnt       <= IDX_W'(WIDTH - 1);
            word      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word     <= in;
                        cnt      <= IDX_W'(WIDTH - 1);
                        in_ready <= 1'b0;
                        if (in == '0) begin
                            state <= DONE;
                            found <= 1'b0;
                            pos   <= '0;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (word[cnt]) begin
                        pos       <= cnt;
                        found     <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - IDX_W'(1);
                    end else begin
                        pos       <= '0;
                        found     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // a zero word enters DONE straight from IDLE, so out_valid is raised one edge later
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
